// File: rtl/ii_dispatch_pkg.sv
// Shared dispatch definitions: reservation-station channel indices, opgen codes
// and the opgen -> channel routing function used by both RS and ROB logic.
package ii_dispatch_pkg;

    localparam int RS_NUM_DEF     = 4;
    localparam int RS_DEPTH_DEF   = 8;
    localparam int DATA_W_DEF     = 32;
    localparam int ROB_ADDR_W_DEF = 6;
    localparam int OPGEN_W_DEF    = 6;
    localparam int EXC_W_DEF      = 4;

    typedef enum logic [1:0] {
        CH_INT = 2'd0,
        CH_MDU = 2'd1,
        CH_LSU = 2'd2,
        CH_BRU = 2'd3
    } rs_chan_e;

    typedef enum logic [OPGEN_W_DEF-1:0] {
        OP_NOP   = 6'd0,  OP_ADD  = 6'd1,  OP_ADDU  = 6'd2,  OP_SUB  = 6'd3,
        OP_SUBU  = 6'd4,  OP_AND  = 6'd5,  OP_OR    = 6'd6,  OP_XOR  = 6'd7,
        OP_NOR   = 6'd8,  OP_SLT  = 6'd9,  OP_SLTU  = 6'd10, OP_SLL  = 6'd11,
        OP_SRL   = 6'd12, OP_SRA  = 6'd13, OP_CLZ   = 6'd14, OP_CLO  = 6'd15,
        OP_MOVZ  = 6'd16, OP_MOVN = 6'd17,
        OP_DIV   = 6'd18, OP_DIVU = 6'd19, OP_MULT  = 6'd20, OP_MULTU = 6'd21,
        OP_MSUB  = 6'd22, OP_MSUBU = 6'd23, OP_MUL  = 6'd24,
        OP_MEM   = 6'd25,
        OP_BEQ   = 6'd26, OP_BNE  = 6'd27, OP_BLEZ  = 6'd28, OP_BGTZ = 6'd29,
        OP_BLTZ  = 6'd30, OP_BGEZ = 6'd31, OP_J     = 6'd32, OP_JR   = 6'd33
    } opgen_e;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

    typedef struct packed {
        logic     valid;
        rs_chan_e chan;
    } chan_sel_t;

    // Unlisted codes come back with valid=0 so the dispatcher can discard them.
    function automatic chan_sel_t opgen_to_chan(input logic [OPGEN_W_DEF-1:0] op);
        chan_sel_t sel;
        sel.valid = 1'b1;
        sel.chan  = CH_INT;
        case (op)
            OP_NOP, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR,
            OP_NOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_CLZ, OP_CLO,
            OP_MOVZ, OP_MOVN:                                   sel.chan = CH_INT;
            OP_DIV, OP_DIVU, OP_MULT, OP_MULTU, OP_MSUB, OP_MSUBU,
            OP_MUL:                                             sel.chan = CH_MDU;
            OP_MEM:                                             sel.chan = CH_LSU;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ,
            OP_J, OP_JR:                                        sel.chan = CH_BRU;
            default:                                            sel.valid = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ii_credit_counter.sv
// Free-entry credit tracker for one reservation station; saturates at RS_DEPTH
// so a spurious release can never grant more entries than the station owns.
module ii_credit_counter #(
    parameter int RS_DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_issue,
    input  logic i_release,
    input  logic i_flush,
    output logic o_credit_ok
);

    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    logic [CNT_W-1:0] r_credit;
    logic             w_inc;

    assign w_inc       = i_release && (r_credit != CNT_W'(RS_DEPTH));
    assign o_credit_ok = (r_credit != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit <= CNT_W'(RS_DEPTH);
        end else if (i_flush) begin
            r_credit <= CNT_W'(RS_DEPTH);
        end else begin
            r_credit <= r_credit - CNT_W'(i_issue) + CNT_W'(w_inc);
        end
    end

endmodule

// File: rtl/ii_dispatch.sv
// Instruction dispatcher: routes one instruction per cycle to a reservation station
// by opgen, holding it (and stalling upstream) while the target station has no credit.
module ii_dispatch
    import ii_dispatch_pkg::*;
#(
    parameter int RS_NUM     = RS_NUM_DEF,
    parameter int RS_DEPTH   = RS_DEPTH_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ROB_ADDR_W = ROB_ADDR_W_DEF,
    parameter int OPGEN_W    = OPGEN_W_DEF,
    parameter int EXC_W      = EXC_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_can_issue,
    input  logic [ROB_ADDR_W-1:0] i_rob_addr,
    input  logic [OPGEN_W-1:0]    i_opgen,
    input  logic [EXC_W-1:0]      i_exception_type,
    input  logic                  i_operand_is_ref_1,
    input  logic                  i_operand_is_ref_2,
    input  logic [DATA_W-1:0]     i_operand_data_1,
    input  logic [DATA_W-1:0]     i_operand_data_2,
    input  logic [DATA_W-1:0]     i_pc,
    input  logic [RS_NUM-1:0]     i_rs_release,
    output logic                  o_stall_request,
    output logic [RS_NUM-1:0]     o_rs_wen,
    output logic [ROB_ADDR_W-1:0] o_rob_addr,
    output logic [OPGEN_W-1:0]    o_opgen,
    output logic [EXC_W-1:0]      o_exception_type,
    output logic                  o_operand_is_ref_1,
    output logic                  o_operand_is_ref_2,
    output logic [DATA_W-1:0]     o_operand_data_1,
    output logic [DATA_W-1:0]     o_operand_data_2,
    output logic [DATA_W-1:0]     o_pc,
    output logic                  o_drop_pulse
);

    hold_state_e           r_state;
    hold_state_e           w_state_next;
    logic [ROB_ADDR_W-1:0] r_hold_rob_addr;
    logic [OPGEN_W-1:0]    r_hold_opgen;
    logic [EXC_W-1:0]      r_hold_exception_type;
    logic                  r_hold_is_ref_1;
    logic                  r_hold_is_ref_2;
    logic [DATA_W-1:0]     r_hold_data_1;
    logic [DATA_W-1:0]     r_hold_data_2;
    logic [DATA_W-1:0]     r_hold_pc;

    logic                  w_hold_valid;
    logic                  w_src_valid;
    chan_sel_t             w_sel;
    logic [RS_NUM-1:0]     w_credit_ok;
    logic [RS_NUM-1:0]     w_rs_wen;
    logic                  w_drop;
    logic                  w_capture;

    assign w_hold_valid = (r_state == HOLD_FULL);
    assign w_src_valid  = w_hold_valid || i_can_issue;

    // Payload always follows the selected source; rs_wen qualifies it.
    assign o_rob_addr         = w_hold_valid ? r_hold_rob_addr       : i_rob_addr;
    assign o_opgen            = w_hold_valid ? r_hold_opgen          : i_opgen;
    assign o_exception_type   = w_hold_valid ? r_hold_exception_type : i_exception_type;
    assign o_operand_is_ref_1 = w_hold_valid ? r_hold_is_ref_1       : i_operand_is_ref_1;
    assign o_operand_is_ref_2 = w_hold_valid ? r_hold_is_ref_2       : i_operand_is_ref_2;
    assign o_operand_data_1   = w_hold_valid ? r_hold_data_1         : i_operand_data_1;
    assign o_operand_data_2   = w_hold_valid ? r_hold_data_2         : i_operand_data_2;
    assign o_pc               = w_hold_valid ? r_hold_pc             : i_pc;

    assign w_sel = opgen_to_chan(OPGEN_W_DEF'(o_opgen));

    genvar g;
    generate
        for (g = 0; g < RS_NUM; g++) begin : g_chan
            ii_credit_counter #(
                .RS_DEPTH (RS_DEPTH)
            ) u_credit (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_issue     (w_rs_wen[g]),
                .i_release   (i_rs_release[g]),
                .i_flush     (i_flush),
                .o_credit_ok (w_credit_ok[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HOLD_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Only the input port can carry an unmapped opgen; the hold register never captures one.
    always_comb begin
        w_state_next = r_state;
        w_rs_wen     = '0;
        w_drop       = 1'b0;
        w_capture    = 1'b0;
        if (i_flush) begin
            w_state_next = HOLD_EMPTY;
        end else if (rst_n && w_src_valid) begin
            if (!w_sel.valid) begin
                w_drop = 1'b1;
            end else if (w_credit_ok[w_sel.chan]) begin
                w_rs_wen[w_sel.chan] = 1'b1;
                w_state_next         = HOLD_EMPTY;
            end else if (!w_hold_valid) begin
                w_capture    = 1'b1;
                w_state_next = HOLD_FULL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_rob_addr       <= '0;
            r_hold_opgen          <= '0;
            r_hold_exception_type <= '0;
            r_hold_is_ref_1       <= 1'b0;
            r_hold_is_ref_2       <= 1'b0;
            r_hold_data_1         <= '0;
            r_hold_data_2         <= '0;
            r_hold_pc             <= '0;
        end else if (w_capture) begin
            r_hold_rob_addr       <= i_rob_addr;
            r_hold_opgen          <= i_opgen;
            r_hold_exception_type <= i_exception_type;
            r_hold_is_ref_1       <= i_operand_is_ref_1;
            r_hold_is_ref_2       <= i_operand_is_ref_2;
            r_hold_data_1         <= i_operand_data_1;
            r_hold_data_2         <= i_operand_data_2;
            r_hold_pc             <= i_pc;
        end
    end

    assign o_rs_wen        = w_rs_wen;
    assign o_drop_pulse    = w_drop;
    assign o_stall_request = w_hold_valid;

endmodule

// File: tb/tb_ii_dispatch.sv
// Self-checking bench for ii_dispatch: a credit/hold model predicts every cycle's
// outputs, and directed scenarios add hand-computed literal expectations.
module tb_ii_dispatch;
    import ii_dispatch_pkg::*;

    localparam int NCH   = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int OW    = 6;
    localparam int EW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_can_issue = 1'b0;
    logic [AW-1:0] i_rob_addr = '0;
    logic [OW-1:0] i_opgen = '0;
    logic [EW-1:0] i_exception_type = '0;
    logic          i_operand_is_ref_1 = 1'b0;
    logic          i_operand_is_ref_2 = 1'b0;
    logic [DW-1:0] i_operand_data_1 = '0;
    logic [DW-1:0] i_operand_data_2 = '0;
    logic [DW-1:0] i_pc = '0;
    logic [NCH-1:0] i_rs_release = '0;
    logic          o_stall_request;
    logic [NCH-1:0] o_rs_wen;
    logic [AW-1:0] o_rob_addr;
    logic [OW-1:0] o_opgen;
    logic [EW-1:0] o_exception_type;
    logic          o_operand_is_ref_1;
    logic          o_operand_is_ref_2;
    logic [DW-1:0] o_operand_data_1;
    logic [DW-1:0] o_operand_data_2;
    logic [DW-1:0] o_pc;
    logic          o_drop_pulse;

    always #5 clk = ~clk;

    ii_dispatch #(
        .RS_NUM(NCH), .RS_DEPTH(DEPTH), .DATA_W(DW),
        .ROB_ADDR_W(AW), .OPGEN_W(OW), .EXC_W(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_can_issue(i_can_issue),
        .i_rob_addr(i_rob_addr), .i_opgen(i_opgen), .i_exception_type(i_exception_type),
        .i_operand_is_ref_1(i_operand_is_ref_1), .i_operand_is_ref_2(i_operand_is_ref_2),
        .i_operand_data_1(i_operand_data_1), .i_operand_data_2(i_operand_data_2),
        .i_pc(i_pc), .i_rs_release(i_rs_release), .o_stall_request(o_stall_request),
        .o_rs_wen(o_rs_wen), .o_rob_addr(o_rob_addr), .o_opgen(o_opgen),
        .o_exception_type(o_exception_type), .o_operand_is_ref_1(o_operand_is_ref_1),
        .o_operand_is_ref_2(o_operand_is_ref_2), .o_operand_data_1(o_operand_data_1),
        .o_operand_data_2(o_operand_data_2), .o_pc(o_pc), .o_drop_pulse(o_drop_pulse)
    );

    int nChecks = 0;
    int nFails  = 0;

    int            mCredit [NCH];
    bit            mHoldValid;
    logic [127:0]  mHoldPayload;
    logic [OW-1:0] mHoldOp;

    // Channel routing by opcode range: INT 0-17, MDU 18-24, MEM 25, BRU 26-33.
    function automatic int chanOf(input logic [OW-1:0] op);
        int v;
        v = int'(op);
        if (v <= 17) return 0;
        if (v <= 24) return 1;
        if (v == 25) return 2;
        if (v <= 33) return 3;
        return -1;
    endfunction

    function automatic logic [127:0] inPayload();
        return 128'({i_rob_addr, i_opgen, i_exception_type, i_operand_is_ref_1,
                     i_operand_is_ref_2, i_operand_data_1, i_operand_data_2, i_pc});
    endfunction

    function automatic logic [127:0] outPayload();
        return 128'({o_rob_addr, o_opgen, o_exception_type, o_operand_is_ref_1,
                     o_operand_is_ref_2, o_operand_data_1, o_operand_data_2, o_pc});
    endfunction

    // Expected combinational behaviour for the current cycle from model state and inputs.
    function automatic void predict(output logic [NCH-1:0] wen, output bit drop,
                                    output bit capture, output logic [127:0] pay);
        int c;
        wen     = '0;
        drop    = 1'b0;
        capture = 1'b0;
        pay     = mHoldValid ? mHoldPayload : inPayload();
        if (!rst_n || i_flush) return;
        if (mHoldValid) begin
            c = chanOf(mHoldOp);
            if (c >= 0 && mCredit[c] > 0) wen[c] = 1'b1;
        end else if (i_can_issue) begin
            c = chanOf(i_opgen);
            if (c < 0)                drop = 1'b1;
            else if (mCredit[c] > 0)  wen[c] = 1'b1;
            else                      capture = 1'b1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model state advances on each edge using the spec's credit and hold rules.
    always @(posedge clk or negedge rst_n) begin : model
        logic [NCH-1:0] wen;
        bit             drop;
        bit             capture;
        logic [127:0]   pay;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) mCredit[c] <= DEPTH;
            mHoldValid   <= 1'b0;
            mHoldPayload <= '0;
            mHoldOp      <= '0;
        end else if (i_flush) begin
            for (int c = 0; c < NCH; c++) mCredit[c] <= DEPTH;
            mHoldValid <= 1'b0;
        end else begin
            predict(wen, drop, capture, pay);
            for (int c = 0; c < NCH; c++)
                mCredit[c] <= mCredit[c] - int'(wen[c])
                              + ((i_rs_release[c] && mCredit[c] < DEPTH) ? 1 : 0);
            if (capture) begin
                mHoldValid   <= 1'b1;
                mHoldPayload <= inPayload();
                mHoldOp      <= i_opgen;
            end else if (wen != '0) begin
                mHoldValid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [NCH-1:0] wen;
        bit             drop;
        bit             capture;
        logic [127:0]   pay;
        predict(wen, drop, capture, pay);
        checkOutput("rs_wen", 128'(o_rs_wen), 128'(wen));
        checkOutput("drop_pulse", 128'(o_drop_pulse), 128'(drop));
        checkOutput("stall_request", 128'(o_stall_request), 128'(mHoldValid));
        if (wen != '0) checkOutput("payload", outPayload(), pay);
    end

    // Drive one cycle of inputs just after the edge, return at the following negedge.
    task automatic applyStimulus(input bit valid, input logic [OW-1:0] op,
                                 input logic [NCH-1:0] rel, input bit fl);
        @(posedge clk);
        #1;
        i_can_issue        = valid;
        i_opgen            = op;
        i_rs_release       = rel;
        i_flush            = fl;
        i_rob_addr         = AW'($urandom);
        i_exception_type   = EW'($urandom);
        i_operand_is_ref_1 = 1'($urandom);
        i_operand_is_ref_2 = 1'($urandom);
        i_operand_data_1   = $urandom;
        i_operand_data_2   = $urandom;
        i_pc               = $urandom;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, OP_NOP, '0, 1'b0);
    endtask

    initial begin
        i_can_issue = 1'b1;
        i_opgen     = OP_ADD;
        repeat (2) @(negedge clk);
        checkOutput("reset_wen", 128'(o_rs_wen), 128'(0));
        checkOutput("reset_stall", 128'(o_stall_request), 128'(0));
        @(posedge clk);
        #1;
        i_can_issue = 1'b0;
        rst_n       = 1'b1;

        applyStimulus(1'b1, OP_ADD, '0, 1'b0);
        checkOutput("add_wen", 128'(o_rs_wen), 128'(4'b0001));
        idle();
        checkOutput("model_int_credit", 128'(mCredit[0]), 128'(7));

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, OP_MUL, '0, 1'b0);
            checkOutput("mul_wen", 128'(o_rs_wen), 128'(4'b0010));
        end
        applyStimulus(1'b1, OP_MUL, '0, 1'b0);
        checkOutput("mul9_wen", 128'(o_rs_wen), 128'(0));
        applyStimulus(1'b1, OP_ADD, 4'b0010, 1'b0);
        checkOutput("mul_stall", 128'(o_stall_request), 128'(1));
        checkOutput("mul_nobypass_wen", 128'(o_rs_wen), 128'(0));
        idle();
        checkOutput("mul_held_wen", 128'(o_rs_wen), 128'(4'b0010));
        checkOutput("mul_held_opgen", 128'(o_opgen), 128'(OP_MUL));
        checkOutput("mul_held_stall", 128'(o_stall_request), 128'(1));
        idle();
        checkOutput("mul_stall_drop", 128'(o_stall_request), 128'(0));

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, OP_MEM, '0, 1'b0);
        applyStimulus(1'b1, OP_MEM, 4'b0100, 1'b0);
        checkOutput("lsu_nobypass_wen", 128'(o_rs_wen), 128'(0));
        idle();
        checkOutput("lsu_held_wen", 128'(o_rs_wen), 128'(4'b0100));
        idle();
        checkOutput("lsu_stall_drop", 128'(o_stall_request), 128'(0));
        checkOutput("model_lsu_credit", 128'(mCredit[2]), 128'(0));

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, OP_BEQ, '0, 1'b0);
        applyStimulus(1'b1, OP_BEQ, '0, 1'b0);
        applyStimulus(1'b0, OP_NOP, 4'b1111, 1'b1);
        checkOutput("flush_stall_before", 128'(o_stall_request), 128'(1));
        checkOutput("flush_wen", 128'(o_rs_wen), 128'(0));
        idle();
        checkOutput("flush_stall_after", 128'(o_stall_request), 128'(0));
        for (int c = 0; c < NCH; c++) checkOutput("model_flush_credit", 128'(mCredit[c]), 128'(8));
        applyStimulus(1'b1, OP_MUL, '0, 1'b0);
        checkOutput("flush_mdu_restored", 128'(o_rs_wen), 128'(4'b0010));

        applyStimulus(1'b1, 6'h3F, '0, 1'b0);
        checkOutput("drop_pulse", 128'(o_drop_pulse), 128'(1));
        checkOutput("drop_wen", 128'(o_rs_wen), 128'(0));
        idle();
        checkOutput("drop_no_stall", 128'(o_stall_request), 128'(0));

        for (int i = 0; i < 9; i++) applyStimulus(1'b1, OP_ADD, '0, 1'b0);
        idle();
        checkOutput("int_stall", 128'(o_stall_request), 128'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_stall_immediate", 128'(o_stall_request), 128'(0));
        checkOutput("rst_wen", 128'(o_rs_wen), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, OP_ADD, '0, 1'b0);
            checkOutput("rst_int_credit_wen", 128'(o_rs_wen), 128'(4'b0001));
        end

        applyStimulus(1'b0, OP_NOP, 4'b1000, 1'b0);
        applyStimulus(1'b0, OP_NOP, 4'b1000, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, OP_JR, '0, 1'b0);
        applyStimulus(1'b1, OP_J, '0, 1'b0);
        checkOutput("bru_full_release_ignored", 128'(o_rs_wen), 128'(0));
        applyStimulus(1'b0, OP_NOP, '0, 1'b1);
        repeat (2) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ii_dispatch.md
II_DISPATCH -- requirements
Module: ii_dispatch

Interface
REQ-001 Parameter RS_NUM, default 4, number of reservation-station channels (0=INT, 1=MDU, 2=LSU, 3=BRU).
REQ-002 Parameter RS_DEPTH, default 8, entries per reservation station; initial credit per channel.
REQ-003 Parameter DATA_W, default 32, operand and PC width.
REQ-004 Parameter ROB_ADDR_W, default `ROB_ADDR_W; OPGEN_W, default `OPGEN_W; EXC_W, default `EXC_TYPE_W.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 flush  in  1  pipeline flush; all reservation stations clear in the same cycle.
REQ-008 can_issue_in  in  1  upstream instruction valid this cycle.
REQ-009 rob_addr_in  in  ROB_ADDR_W  ROB slot of the instruction.
REQ-010 opgen_in  in  OPGEN_W  operation code; selects channel.
REQ-011 exception_type_in  in  EXC_W  exception bits.
REQ-012 operand_is_ref_1_in / operand_is_ref_2_in  in  1 each  operand is a ROB tag, not a value.
REQ-013 operand_data_1_in / operand_data_2_in  in  DATA_W each  operand value or tag.
REQ-014 pc_in  in  DATA_W  instruction PC.
REQ-015 rs_release  in  RS_NUM  one-cycle pulse per channel: one RS entry freed.
REQ-016 stall_request  out  1  upstream must hold its current instruction.
REQ-017 rs_wen  out  RS_NUM  one-hot write enable to the selected RS.
REQ-018 rob_addr_out, opgen_out, exception_type_out, operand_is_ref_1/2_out, operand_data_1/2_out, pc_out  out  widths as inputs  write-channel payload.
REQ-019 drop_pulse  out  1  unmapped opgen discarded this cycle.

Function
REQ-020 Channel map: ALU/shift/CLZ/CLO/MOVZ/MOVN/NOP -> 0; DIV/DIVU/MULT/MULTU/MSUB/MSUBU/MUL -> 1; MEM -> 2; branches/J/JR -> 3; any other opgen -> unmapped.
REQ-021 Per channel: credit counter, width $clog2(RS_DEPTH+1).
REQ-022 Source = hold register when hold_valid=1, else input port; can_issue_in ignored while hold_valid=1.
REQ-023 Issue condition: source valid, channel mapped, registered credit>0; no same-cycle bypass of rs_release.
REQ-024 On issue: rs_wen one-hot for that channel, combinational, same cycle; payload driven from the source.
REQ-025 Credit next = credit - issue + release; simultaneous issue and release leaves credit unchanged.
REQ-026 Release at credit==RS_DEPTH is ignored; credit never exceeds RS_DEPTH or underflows.
REQ-027 Input valid but credit==0: capture payload into hold register, set hold_valid at next edge, rs_wen=0.
REQ-028 stall_request = hold_valid (registered); it asserts the cycle after capture and deasserts the cycle after the held instruction issues.
REQ-029 Held instruction issues in the first cycle its channel credit is >0; hold_valid clears at that edge.
REQ-030 Unmapped opgen from input: drop_pulse=1, rs_wen=0, no capture, no stall.
REQ-031 flush has highest priority: rs_wen=0 and drop_pulse=0 that cycle; hold_valid cleared and all credits set to RS_DEPTH at the edge; rs_release that cycle ignored.
REQ-032 rs_wen is at most one-hot in every cycle.

Reset
REQ-033 While rst=0: credits=RS_DEPTH, hold_valid=0, hold payload=0, stall_request=0, rs_wen=0, drop_pulse=0; payload outputs mux zero hold payload.
REQ-034 Reset mid-stall discards the held instruction with no write to any RS.

Structure
REQ-035 Channel indices, RS_NUM default, and the opgen->channel function go in a shared package shared by RS and ROB logic.
REQ-036 One sub-module, ii_credit_counter (one per channel, generate loop): issue/release/flush in, credit_ok out.

Verification
REQ-037 Reset, ADD with can_issue_in=1 -> rs_wen=4'b0001 same cycle; INT credit 8->7.
REQ-038 Nine MUL, no releases -> eight rs_wen=4'b0010; ninth held, stall_request=1 next cycle; rs_release[1] pulse -> held MUL issues the cycle after, stall drops the following cycle.
REQ-039 LSU credit=0 and rs_release[2]=1 with MEM input in same cycle -> no issue (no bypass), MEM captured; issues next cycle, credit ends 0.
REQ-040 Held BEQ with flush=1 -> rs_wen=0; next cycle hold_valid=0, stall=0, all credits=8.
REQ-041 Unknown opgen=all-ones -> drop_pulse=1, rs_wen=0, stall_request stays 0.
REQ-042 rst low for one cycle during a stall -> stall_request=0 immediately, credits=8, no rs_wen.
